// File: rtl/conv_pkg.sv
// conv_pkg: shared latency, FSM encoding and fixed-point helpers for the conv layer.
package conv_pkg;
    localparam int LAT = 4;
    typedef enum logic [2:0] {S_EMPTY, S_LOAD, S_READY, S_RUN, S_DRAIN} state_e;
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    // Drop frac bits (floor) and clamp into the dw-bit signed range
    function automatic logic signed [63:0] shift_sat(input logic signed [127:0] v, input int frac, input int dw);
        logic signed [127:0] s, mx, mn;
        s  = v >>> frac;
        mx = (128'sd1 <<< (dw - 1)) - 128'sd1;
        mn = -mx - 128'sd1;
        return (s > mx) ? mx[63:0] : (s < mn) ? mn[63:0] : s[63:0];
    endfunction
endpackage

// File: rtl/conv_filter_mac.sv
// conv_filter_mac: one filter's coefficients and bias, multiply, sum, then bias/round/saturate/ReLU.
module conv_filter_mac
    import conv_pkg::*;
#(
    parameter int N      = 27,
    parameter int DATA_W = 32,
    parameter int FRAC   = 16,
    parameter int RELU   = 1,
    parameter int AW     = 5
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [N*DATA_W-1:0] win_i,
    output logic [DATA_W-1:0]   data_o
);
    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = PW + clog2(N);
    logic signed [DATA_W-1:0] coef_q [N];
    logic signed [DATA_W-1:0] bias_q;
    logic signed [PW-1:0]     prod_d [N];
    logic signed [PW-1:0]     prod_q [N];
    logic signed [ACC_W-1:0]  sum_d, sum_q, biased;
    logic signed [63:0]       sat;
    logic [DATA_W-1:0]        data_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                coef_q[i] <= '0;
                prod_q[i] <= '0;
            end
            bias_q <= '0;
            sum_q  <= '0;
            data_o <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en_i && wr_addr_i == AW'(i)) coef_q[i] <= wr_data_i;
                prod_q[i] <= prod_d[i];
            end
            if (wr_en_i && wr_addr_i == AW'(N)) bias_q <= wr_data_i;
            sum_q  <= sum_d;
            data_o <= data_d;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) begin
            prod_d[i] = PW'(coef_q[i]) * PW'($signed(win_i[i*DATA_W +: DATA_W]));
            sum_d     = sum_d + ACC_W'(prod_q[i]);
        end
        biased = sum_q + (ACC_W'(bias_q) <<< FRAC);
        sat    = shift_sat({{(128-ACC_W){biased[ACC_W-1]}}, biased}, FRAC, DATA_W);
        data_d = (RELU != 0 && sat < 0) ? '0 : sat[DATA_W-1:0];
    end
endmodule

// File: rtl/conv_nchanel_nfilter.sv
// conv_nchanel_nfilter: KxK multi-channel, multi-filter convolution with load/run FSM.
// One shared line-buffer/window per channel feeds FILTER parallel MAC pipelines.
module conv_nchanel_nfilter
    import conv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int CHANEL = 3,
    parameter int FILTER = 4,
    parameter int K      = 3,
    parameter int DATA_W = 32,
    parameter int FRAC   = 16,
    parameter int RELU   = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     data_valid_in,
    input  logic [CHANEL*DATA_W-1:0] data_in,
    input  logic                     load_kernel,
    input  logic [DATA_W-1:0]        kernel,
    output logic [FILTER*DATA_W-1:0] data_out,
    output logic                     valid_out,
    output logic                     done_img,
    output logic                     load_kernel_done,
    output logic                     busy,
    output logic                     load_err
);
    localparam int N    = CHANEL * K * K;
    localparam int AW   = clog2(N + 1);
    localparam int FW   = clog2(FILTER);
    localparam int RW   = clog2(HEIGHT);
    localparam int CW   = clog2(WIDTH);
    localparam int SRL  = (K - 1) * WIDTH + K;
    localparam int NOUT = (HEIGHT - K + 1) * (WIDTH - K + 1);
    localparam int OW   = clog2(NOUT);
    localparam int LW   = clog2(LAT);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [FW-1:0]     f_q, f_d, cur_f;
    logic [AW-1:0]     l_q, l_d, cur_l;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [OW-1:0]     ocnt_q;
    logic [LW-1:0]     dcnt_q;
    logic              ld_acc, px_acc, last_word, last_pix, win_ok;
    logic              v1_q, v2_q, v3_q, load_err_q;
    logic [DATA_W-1:0] sr_q [CHANEL][SRL];
    logic [N*DATA_W-1:0] win;

    always_comb begin
        ld_acc    = load_kernel && (state_q == S_EMPTY || state_q == S_LOAD || state_q == S_READY);
        px_acc    = data_valid_in && (state_q == S_RUN || state_q == S_DRAIN || (state_q == S_READY && !load_kernel));
        cur_f     = (state_q == S_LOAD) ? f_q : '0;
        cur_l     = (state_q == S_LOAD) ? l_q : '0;
        last_word = cur_f == FW'(FILTER - 1) && cur_l == AW'(N);
        l_d       = (cur_l == AW'(N)) ? '0 : cur_l + 1'b1;
        f_d       = (cur_l == AW'(N)) ? cur_f + 1'b1 : cur_f;
        last_pix  = row_q == ROW_LAST && col_q == COL_LAST;
        win_ok    = row_q >= RW'(K - 1) && col_q >= CW'(K - 1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_EMPTY;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: state_d = load_kernel ? S_LOAD : S_EMPTY;
            S_LOAD:  state_d = (ld_acc && last_word) ? S_READY : S_LOAD;
            S_READY: state_d = load_kernel ? S_LOAD : px_acc ? (last_pix ? S_DRAIN : S_RUN) : S_READY;
            S_RUN:   state_d = (px_acc && last_pix) ? S_DRAIN : S_RUN;
            S_DRAIN: state_d = px_acc ? (last_pix ? S_DRAIN : S_RUN) : (dcnt_q == LW'(LAT - 1)) ? S_READY : S_DRAIN;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        busy             = state_q == S_RUN;
        load_kernel_done = state_q inside {S_READY, S_RUN, S_DRAIN};
        load_err         = load_err_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f_q        <= '0;
            l_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            ocnt_q     <= '0;
            dcnt_q     <= '0;
            load_err_q <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            valid_out  <= 1'b0;
            done_img   <= 1'b0;
        end else begin
            if (ld_acc) begin
                f_q <= f_d;
                l_q <= l_d;
            end
            if (px_acc) begin
                col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                if (col_q == COL_LAST) row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end
            // Sticky until the next entry into LOAD
            if (load_kernel && (state_q == S_RUN || state_q == S_DRAIN)) load_err_q <= 1'b1;
            else if (ld_acc && state_q != S_LOAD) load_err_q <= 1'b0;
            dcnt_q    <= (state_q == S_DRAIN && !px_acc) ? dcnt_q + 1'b1 : '0;
            v1_q      <= px_acc && win_ok;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            valid_out <= v3_q;
            done_img  <= v3_q && ocnt_q == OW'(NOUT - 1);
            if (v3_q) ocnt_q <= (ocnt_q == OW'(NOUT - 1)) ? '0 : ocnt_q + 1'b1;
        end
    end

    // Per-channel shift chain: offset dr*WIDTH+dc holds the pixel dr rows up, dc cols left
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < CHANEL; c++)
                for (int j = 0; j < SRL; j++) sr_q[c][j] <= '0;
        end else if (px_acc) begin
            for (int c = 0; c < CHANEL; c++) begin
                sr_q[c][0] <= data_in[c*DATA_W +: DATA_W];
                for (int j = 1; j < SRL; j++) sr_q[c][j] <= sr_q[c][j-1];
            end
        end
    end

    always_comb begin
        win = '0;
        for (int c = 0; c < CHANEL; c++)
            for (int r = 0; r < K; r++)
                for (int k = 0; k < K; k++)
                    win[(c*K*K + r*K + k)*DATA_W +: DATA_W] = sr_q[c][(K-1-r)*WIDTH + (K-1-k)];
    end

    for (genvar f = 0; f < FILTER; f++) begin : g_f
        conv_filter_mac #(
            .N(N), .DATA_W(DATA_W), .FRAC(FRAC), .RELU(RELU), .AW(AW)
        ) u_mac (
            .clk       (clk),
            .resetn    (resetn),
            .wr_en_i   (ld_acc && cur_f == FW'(f)),
            .wr_addr_i (cur_l),
            .wr_data_i (kernel),
            .win_i     (win),
            .data_o    (data_out[f*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_conv_nchanel_nfilter.sv
// tb_conv_nchanel_nfilter: directed + random frames checked against a plain-arithmetic
// convolution model, on a ReLU and a non-ReLU instance driven in parallel.
module tb_conv_nchanel_nfilter;
    localparam int W = 5, H = 5, C = 3, F = 4, KS = 3, DW = 16, FR = 8;
    localparam int NPF = C * KS * KS + 1;
    localparam int NW  = F * NPF;

    logic clk = 1'b0, resetn = 1'b0, data_valid_in = 1'b0, load_kernel = 1'b0;
    logic [C*DW-1:0] data_in = '0;
    logic [DW-1:0]   kernel = '0;
    logic [F*DW-1:0] dout0, dout1;
    logic v0, v1, dn0, dn1, ld0, ld1, b0, b1, e0, e1;

    int errors = 0, checks = 0, cyc = 0, done_seen = 0;
    int kern [F][C][KS][KS];
    int bias [F];
    int pix  [C][H][W];

    typedef struct {
        int              due;
        logic [F*DW-1:0] d0;
        logic [F*DW-1:0] d1;
        logic            done;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    bit   ev;

    conv_nchanel_nfilter #(
        .WIDTH(W), .HEIGHT(H), .CHANEL(C), .FILTER(F), .K(KS), .DATA_W(DW), .FRAC(FR), .RELU(0)
    ) u_r0 (
        .clk(clk), .resetn(resetn), .data_valid_in(data_valid_in), .data_in(data_in),
        .load_kernel(load_kernel), .kernel(kernel), .data_out(dout0), .valid_out(v0),
        .done_img(dn0), .load_kernel_done(ld0), .busy(b0), .load_err(e0)
    );

    conv_nchanel_nfilter #(
        .WIDTH(W), .HEIGHT(H), .CHANEL(C), .FILTER(F), .K(KS), .DATA_W(DW), .FRAC(FR), .RELU(1)
    ) u_r1 (
        .clk(clk), .resetn(resetn), .data_valid_in(data_valid_in), .data_in(data_in),
        .load_kernel(load_kernel), .kernel(kernel), .data_out(dout1), .valid_out(v1),
        .done_img(dn1), .load_kernel_done(ld1), .busy(b1), .load_err(e1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    // Windowed sum, bias<<FRAC, floor shift, saturate, optional ReLU
    function automatic logic [DW-1:0] ref_px(input int f, input int y0, input int x0, input bit relu);
        longint acc = 0;
        for (int c = 0; c < C; c++)
            for (int r = 0; r < KS; r++)
                for (int k = 0; k < KS; k++)
                    acc += longint'(kern[f][c][r][k]) * longint'(pix[c][y0+r][x0+k]);
        acc += longint'(bias[f]) * (longint'(1) << FR);
        acc = acc >>> FR;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        return DW'(acc);
    endfunction

    always @(negedge clk) begin
        if (resetn) begin
            ev = q.size() > 0 && q[0].due == cyc;
            if (ev || v0 || v1) begin
                if (ev) mon_e = q.pop_front();
                else mon_e = '{default: '0};
                check("valid_r0", 64'(v0), 64'(ev));
                check("valid_r1", 64'(v1), 64'(ev));
                check("done_r0", 64'(dn0), 64'(mon_e.done));
                check("done_r1", 64'(dn1), 64'(mon_e.done));
                if (ev) begin
                    check("data_r0", dout0, mon_e.d0);
                    check("data_r1", dout1, mon_e.d1);
                end
            end
            if (dn0) done_seen++;
        end
    end

    task automatic load_all();
        int f, l, word;
        for (int i = 0; i < NW; i++) begin
            f = i / NPF;
            l = i % NPF;
            word = (l == NPF - 1) ? bias[f] : kern[f][l / (KS*KS)][(l / KS) % KS][l % KS];
            @(posedge clk); #1;
            if (i == 1) begin
                check("load_err_clr_r0", 64'(e0), 0);
                check("load_err_clr_r1", 64'(e1), 0);
            end
            load_kernel = 1'b1;
            kernel = DW'(word);
            if (i == NW - 1) check("ldone_early", 64'(ld0), 0);
        end
        @(posedge clk); #1;
        load_kernel = 1'b0;
        check("ldone_r0", 64'(ld0), 1);
        check("ldone_r1", 64'(ld1), 1);
        check("ready_not_busy", 64'(b0), 0);
    endtask

    task automatic send_frame(input bit gaps, input int pulse_at, input int npix);
        exp_t e;
        for (int p = 0; p < npix; p++) begin
            int y, x;
            y = p / W;
            x = p % W;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    data_valid_in = 1'b0;
                    load_kernel = 1'b0;
                end
            end
            @(posedge clk); #1;
            if (p == 1) check("busy_run", 64'(b0), 1);
            data_valid_in = 1'b1;
            for (int c = 0; c < C; c++) data_in[c*DW +: DW] = DW'(pix[c][y][x]);
            load_kernel = (p == pulse_at);
            kernel = 16'h1234;
            if (y >= KS - 1 && x >= KS - 1) begin
                e.due  = cyc + 4;
                e.done = (y == H - 1 && x == W - 1);
                for (int f = 0; f < F; f++) begin
                    e.d0[f*DW +: DW] = ref_px(f, y - KS + 1, x - KS + 1, 1'b0);
                    e.d1[f*DW +: DW] = ref_px(f, y - KS + 1, x - KS + 1, 1'b1);
                end
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        data_valid_in = 1'b0;
        load_kernel = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 64'(q.size()), 0);
        repeat (3) @(posedge clk);
        #1;
        check("busy_idle", 64'(b0), 0);
    endtask

    task automatic set_all(input int kv, input int bv, input int pv);
        for (int f = 0; f < F; f++) begin
            bias[f] = bv;
            for (int c = 0; c < C; c++)
                for (int r = 0; r < KS; r++)
                    for (int k = 0; k < KS; k++) kern[f][c][r][k] = kv;
        end
        for (int c = 0; c < C; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) pix[c][y][x] = pv;
    endtask

    task automatic rand_pix();
        for (int c = 0; c < C; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) pix[c][y][x] = int'($urandom_range(0, 8191)) - 4096;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl_r0", {59'd0, v0, dn0, ld0, b0, e0}, 0);
        check("rst_ctrl_r1", {59'd0, v1, dn1, ld1, b1, e1}, 0);
        check("rst_data_r0", dout0, 0);
        check("rst_data_r1", dout1, 0);
        resetn = 1'b1;

        // All-ones kernels on all-ones pixels: 27.0 everywhere
        set_all(256, 0, 256);
        load_all();
        send_frame(1'b0, -1, W * H);
        drain();
        check("done_count_a", 64'(done_seen), 1);

        // Negative bias on filter 1 only, zero pixels
        set_all(256, 0, 0);
        bias[1] = -4096;
        load_all();
        send_frame(1'b0, -1, W * H);
        drain();
        check("done_count_b", 64'(done_seen), 2);

        // Positive and negative saturation
        set_all(32767, 0, 32767);
        load_all();
        send_frame(1'b0, -1, W * H);
        drain();
        set_all(32767, 0, -32767);
        send_frame(1'b0, -1, W * H);
        drain();
        check("done_count_c", 64'(done_seen), 4);

        // Random coefficients, two gapped frames back-to-back
        for (int f = 0; f < F; f++) begin
            bias[f] = int'($urandom_range(0, 4095)) - 2048;
            for (int c = 0; c < C; c++)
                for (int r = 0; r < KS; r++)
                    for (int k = 0; k < KS; k++) kern[f][c][r][k] = int'($urandom_range(0, 511)) - 256;
        end
        load_all();
        rand_pix();
        send_frame(1'b1, -1, W * H);
        rand_pix();
        send_frame(1'b1, -1, W * H);
        drain();
        check("done_count_d", 64'(done_seen), 6);

        // load_kernel during RUN must be ignored and flagged
        rand_pix();
        send_frame(1'b1, 7, W * H);
        check("load_err_r0", 64'(e0), 1);
        check("load_err_r1", 64'(e1), 1);
        drain();
        check("load_err_sticky", 64'(e0), 1);
        check("ldone_kept", 64'(ld0), 1);
        check("done_count_e", 64'(done_seen), 7);
        load_all();

        // Reset in the middle of a frame
        rand_pix();
        send_frame(1'b0, -1, 13);
        resetn = 1'b0;
        q.delete();
        #1;
        check("midrst_ctrl_r0", {59'd0, v0, dn0, ld0, b0, e0}, 0);
        check("midrst_ctrl_r1", {59'd0, v1, dn1, ld1, b1, e1}, 0);
        check("midrst_data_r0", dout0, 0);
        check("midrst_data_r1", dout1, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            data_valid_in = 1'b1;
        end
        @(posedge clk); #1;
        data_valid_in = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("empty_busy", 64'(b0), 0);
        check("empty_ldone_r0", 64'(ld0), 0);
        check("empty_ldone_r1", 64'(ld1), 0);
        check("done_count_f", 64'(done_seen), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
